// File: rtl/coalescing_node_fifo.sv
// coalescing_node_fifo: in-order work list of (node index, path count) entries.
// A push whose node already sits in a valid non-head entry is merged into that
// entry by adding the counts, so each node appears at most once behind the head.
// The head is never a merge target, which keeps pop_* stable while pop_valid_o=1.
// Optional feature macro: ACCUM_SAT_EN -- when defined, an overflowing merge
// stores all-ones; otherwise it wraps. Either way the sticky overflow flag is set.
module coalescing_node_fifo #(
  parameter int PARAM_NODE_IDX_WIDTH  = 9,
  parameter int PARAM_ACCUM_VAL_WIDTH = 24,
  parameter int PARAM_FIFO_DEPTH      = 32
) (
  input  logic                                     clk_i,
  input  logic                                     rst_n_i,
  input  logic                                     clear_i,
  input  logic                                     push_valid_i,
  output logic                                     push_ready_o,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0]          push_node_idx_i,
  input  logic [PARAM_ACCUM_VAL_WIDTH-1:0]         push_accum_i,
  output logic                                     pop_valid_o,
  input  logic                                     pop_ready_i,
  output logic [PARAM_NODE_IDX_WIDTH-1:0]          pop_node_idx_o,
  output logic [PARAM_ACCUM_VAL_WIDTH-1:0]         pop_accum_o,
  output logic [$clog2(PARAM_FIFO_DEPTH+1)-1:0]    count_o,
  output logic                                     overflow_o
);

  localparam int NW    = PARAM_NODE_IDX_WIDTH;
  localparam int AW    = PARAM_ACCUM_VAL_WIDTH;
  localparam int DEPTH = PARAM_FIFO_DEPTH;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]  valid_q;
  logic [NW-1:0]     node_q  [DEPTH];
  logic [AW-1:0]     accum_q [DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;

  logic              hit;
  logic [PW-1:0]     hit_idx;
  logic              push_fire, pop_fire, alloc, merge;
  logic [AW:0]       sum_w;
  logic [AW-1:0]     merged_val;

  // Find the single valid non-head entry holding the pushed node, if any.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (PW'(i) != rd_ptr_q) && (node_q[i] == push_node_idx_i)) begin
        hit     = 1'b1;
        hit_idx = PW'(i);
      end
    end
  end

  assign push_ready_o = hit | (count_q < CW'(DEPTH));
  assign push_fire    = push_valid_i & push_ready_o;
  assign merge        = push_fire & hit;
  assign alloc        = push_fire & ~hit;
  assign pop_valid_o  = valid_q[rd_ptr_q];
  assign pop_fire     = pop_valid_o & pop_ready_i;

  assign pop_node_idx_o = pop_valid_o ? node_q[rd_ptr_q]  : '0;
  assign pop_accum_o    = pop_valid_o ? accum_q[rd_ptr_q] : '0;
  assign count_o        = count_q;
  assign overflow_o     = overflow_q;

  // Merge adder is one bit wider so the carry flags overflow.
  always_comb begin
    sum_w = {1'b0, accum_q[hit_idx]} + {1'b0, push_accum_i};
`ifdef ACCUM_SAT_EN
    merged_val = sum_w[AW] ? {AW{1'b1}} : sum_w[AW-1:0];
`else
    merged_val = sum_w[AW-1:0];
`endif
  end

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clear_i) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (pop_fire)
        rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      if (alloc)
        wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      case ({alloc, pop_fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (merge && sum_w[AW])
        overflow_d = 1'b1;
    end
  end

  // Control registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage: allocate at the tail, merge in place, invalidate the head on pop.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        node_q[i]  <= '0;
        accum_q[i] <= '0;
      end
    end else if (clear_i) begin
      valid_q <= '0;
    end else begin
      if (pop_fire)
        valid_q[rd_ptr_q] <= 1'b0;
      if (merge)
        accum_q[hit_idx] <= merged_val;
      if (alloc) begin
        valid_q[wr_ptr_q] <= 1'b1;
        node_q[wr_ptr_q]  <= push_node_idx_i;
        accum_q[wr_ptr_q] <= push_accum_i;
      end
    end
  end

endmodule

// File: tb/tb_coalescing_node_fifo.sv
// Bench for coalescing_node_fifo: directed scenarios plus random traffic, all
// checked against a queue-based model of the work list.
module tb_coalescing_node_fifo;

  localparam int  NW    = 9;
  localparam int  AW    = 24;
  localparam int  DEPTH = 32;
  localparam int  CW    = $clog2(DEPTH + 1);
  localparam longint MAXV = (64'd1 << AW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          clear_i;
  logic          push_valid_i;
  logic          push_ready_o;
  logic [NW-1:0] push_node_idx_i;
  logic [AW-1:0] push_accum_i;
  logic          pop_valid_o;
  logic          pop_ready_i;
  logic [NW-1:0] pop_node_idx_o;
  logic [AW-1:0] pop_accum_o;
  logic [CW-1:0] count_o;
  logic          overflow_o;

  coalescing_node_fifo #(
    .PARAM_NODE_IDX_WIDTH (NW),
    .PARAM_ACCUM_VAL_WIDTH(AW),
    .PARAM_FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .clear_i        (clear_i),
    .push_valid_i   (push_valid_i),
    .push_ready_o   (push_ready_o),
    .push_node_idx_i(push_node_idx_i),
    .push_accum_i   (push_accum_i),
    .pop_valid_o    (pop_valid_o),
    .pop_ready_i    (pop_ready_i),
    .pop_node_idx_o (pop_node_idx_o),
    .pop_accum_o    (pop_accum_o),
    .count_o        (count_o),
    .overflow_o     (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { int node; longint acc; } ent_t;
  ent_t   mq[$];
  bit     m_ovf;
  int     n_tests = 0;
  int     n_fail  = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int find_hit(input int node);
    for (int j = 1; j < mq.size(); j++)
      if (mq[j].node == node) return j;
    return -1;
  endfunction

  task automatic set_in(input bit v, input int n, input longint a, input bit pr, input bit clr);
    push_valid_i    = v;
    push_node_idx_i = NW'(n);
    push_accum_i    = AW'(a);
    pop_ready_i     = pr;
    clear_i         = clr;
  endtask

  // One clock: drive at negedge, compare all outputs, then advance the model at posedge.
  task automatic cycle(input bit v, input int n, input longint a, input bit pr, input bit clr);
    int     hit;
    bit     rdy;
    longint sum;
    ent_t   e;
    set_in(v, n, a, pr, clr);
    #1;
    hit = find_hit(n);
    rdy = (hit >= 0) || (mq.size() < DEPTH);
    chk("push_ready", push_ready_o, rdy);
    chk("pop_valid",  pop_valid_o, mq.size() > 0);
    chk("pop_node",   pop_node_idx_o, mq.size() > 0 ? mq[0].node : 0);
    chk("pop_accum",  pop_accum_o, mq.size() > 0 ? mq[0].acc : 0);
    chk("count",      count_o, mq.size());
    chk("overflow",   overflow_o, m_ovf);
    @(posedge clk_i);
    if (clr) begin
      mq.delete();
      m_ovf = 0;
    end else begin
      if (v && rdy && hit >= 0) begin
        e   = mq[hit];
        sum = e.acc + a;
        if (sum > MAXV) m_ovf = 1;
`ifdef ACCUM_SAT_EN
        e.acc = (sum > MAXV) ? MAXV : sum;
`else
        e.acc = sum & MAXV;
`endif
        mq[hit] = e;
      end
      if (pr && mq.size() > 0) void'(mq.pop_front());
      if (v && rdy && hit < 0) mq.push_back('{n, a});
    end
    @(negedge clk_i);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n_i = 1'b0;
    set_in(0, 0, 0, 0, 0);
    m_ovf = 0;
    #1;
    chk("rst_pop_valid", pop_valid_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_overflow", overflow_o, 0);
    chk("rst_pop_node", pop_node_idx_o, 0);
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    #1;
    chk("rst_push_ready", push_ready_o, 1);
    @(negedge clk_i);

    // merge into a non-head entry
    cycle(1, 5, 1, 0, 0);
    cycle(1, 7, 2, 0, 0);
    cycle(1, 7, 3, 0, 0);
    chk("t1_count", count_o, 2);
    cycle(0, 0, 0, 1, 0);
    chk("t1_node2", pop_node_idx_o, 7);
    chk("t1_acc2", pop_accum_o, 5);
    cycle(0, 0, 0, 1, 0);
    chk("t1_empty", count_o, 0);

    // head exclusion
    cycle(1, 5, 1, 0, 0);
    cycle(1, 5, 4, 0, 0);
    chk("t2_count", count_o, 2);
    cycle(0, 0, 0, 1, 0);
    chk("t2_acc2", pop_accum_o, 4);
    cycle(0, 0, 0, 1, 0);

    // full
    for (int i = 0; i < DEPTH; i++) cycle(1, i, 1, 0, 0);
    chk("t3_count", count_o, 32);
    set_in(1, 40, 1, 0, 0); #1;
    chk("t3_new_when_full", push_ready_o, 0);
    cycle(1, 40, 1, 0, 0);
    cycle(1, 31, 1, 0, 0);
    chk("t3_merge_full_count", count_o, 32);
    set_in(1, 0, 1, 0, 0); #1;
    chk("t3_head_when_full", push_ready_o, 0);
    cycle(1, 0, 1, 0, 0);
    set_in(1, 40, 1, 1, 0); #1;
    chk("t3_full_with_pop", push_ready_o, 0);
    cycle(1, 40, 1, 1, 0);
    for (int i = 0; i < DEPTH - 2; i++) cycle(0, 0, 0, 1, 0);
    chk("t3_last_node", pop_node_idx_o, 31);
    chk("t3_last_acc", pop_accum_o, 2);
    cycle(0, 0, 0, 1, 0);

    // overflow
    cycle(1, 3, 1, 0, 0);
    cycle(1, 9, 'hFFFFFF, 0, 0);
    cycle(1, 9, 2, 0, 0);
    chk("t4_ovf", overflow_o, 1);
    cycle(0, 0, 0, 1, 0);
`ifdef ACCUM_SAT_EN
    chk("t4_acc", pop_accum_o, 'hFFFFFF);
`else
    chk("t4_acc", pop_accum_o, 'h000001);
`endif
    cycle(0, 0, 0, 0, 1);
    chk("t4_clr_ovf", overflow_o, 0);
    chk("t4_clr_cnt", count_o, 0);

    // concurrency
    cycle(1, 4, 1, 0, 0);
    cycle(1, 6, 2, 1, 0);
    chk("t5_count", count_o, 1);
    chk("t5_node", pop_node_idx_o, 6);
    chk("t5_acc", pop_accum_o, 2);
    cycle(1, 8, 1, 0, 1);
    chk("t5_clr_push", count_o, 0);

    // asynchronous reset mid-cycle
    for (int i = 0; i < 10; i++) cycle(1, 10 + i, i + 1, 0, 0);
    set_in(0, 0, 0, 0, 0);
    #2 rst_n_i = 1'b0;
    #1;
    chk("t6_pop_valid", pop_valid_o, 0);
    chk("t6_count", count_o, 0);
    chk("t6_pop_node", pop_node_idx_o, 0);
    chk("t6_pop_acc", pop_accum_o, 0);
    mq.delete();
    m_ovf = 0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    #1;
    chk("t6_push_ready", push_ready_o, 1);
    @(negedge clk_i);

    // random traffic: small node range for frequent merges and fills
    for (int k = 0; k < 3000; k++) begin
      bit     v, pr, clr;
      int     n;
      longint a;
      v   = ($urandom_range(0, 3) != 0);
      n   = $urandom_range(0, 39);
      a   = ($urandom_range(0, 9) == 0) ? longint'($urandom_range(0, 32'hFFFFFF))
                                        : longint'($urandom_range(0, 15));
      pr  = (k % 400 < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      clr = ($urandom_range(0, 299) == 0);
      cycle(v, n, a, pr, clr);
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
